// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - request/response bundle between ID/EX and the HI/LO multiply/divide unit
interface hilo_muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (output start, op, a, b, input busy, done, hi_out, lo_out);
  modport slave  (input start, op, a, b, output busy, done, hi_out, lo_out);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - multi-cycle MULT/DIV unit owning the architectural HI/LO registers
module hilo_muldiv_unit #(
  parameter int MULT_LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset,
  hilo_muldiv_unit_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_signed;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_rq;

  logic        w_is_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;
  logic [63:0] w_shift;
  logic [32:0] w_diff;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign w_a_mag     = (w_is_signed && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
  assign w_b_mag     = (w_is_signed && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

  // Sign- or zero-extend the latched operands; the low 64 bits of the product are exact either way.
  assign w_ma   = {{32{r_signed & r_a[31]}}, r_a};
  assign w_mb   = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod = w_ma * w_mb;

  // Restoring step: remainder in the upper half, quotient bits shift in from the bottom.
  assign w_shift = {r_rq[62:0], 1'b0};
  assign w_diff  = {1'b0, w_shift[63:32]} - {1'b0, r_b};
  assign w_q     = r_rq[31:0];
  assign w_r     = r_rq[63:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_signed <= (bus.op == OP_MULT);
                r_cnt    <= 5'(MULT_LATENCY - 1);
                r_busy   <= 1'b1;
                r_state  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                r_a      <= bus.a;
                r_b      <= w_b_mag;
                r_signed <= w_is_signed;
                r_neg_q  <= w_is_signed && (bus.a[31] ^ bus.b[31]);
                r_neg_r  <= w_is_signed && bus.a[31];
                r_rq     <= {32'd0, w_a_mag};
                r_cnt    <= 5'd31;
                r_busy   <= 1'b1;
                r_state  <= S_DIV;
              end
              OP_MTHI: r_hi <= bus.a;
              OP_MTLO: r_lo <= bus.a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (r_cnt == 5'd0) begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_DIV: begin
          if (w_diff[32]) begin
            r_rq <= w_shift;
          end else begin
            r_rq <= {w_diff[31:0], w_shift[31:1], 1'b1};
          end
          if (r_cnt == 5'd0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        default: begin
          // r_b holds the divisor magnitude, which is zero exactly when the divisor was zero.
          if (r_b == 32'd0) begin
            r_hi <= r_a;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= r_neg_r ? (32'd0 - w_r) : w_r;
            r_lo <= r_neg_q ? (32'd0 - w_q) : w_q;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.hi_out = r_hi;
  assign bus.lo_out = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard bench for hilo_muldiv_unit with directed vectors
module tb_hilo_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   bcnt = 0;
  int   t_done = 0;
  exp_t exp_q[$];

  hilo_muldiv_unit_if u_if ();

  hilo_muldiv_unit #(.MULT_LATENCY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse and checks HI/LO and the busy window length.
  always @(negedge clk) begin
    if (u_if.done === 1'b1) begin
      t_done = cyc;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (u_if.hi_out !== e.hi || u_if.lo_out !== e.lo || bcnt != e.lat) begin
          n_err++;
          $display("FAIL %s: got hi=0x%08h lo=0x%08h busy=%0d expected hi=0x%08h lo=0x%08h busy=%0d",
                   e.name, u_if.hi_out, u_if.lo_out, bcnt, e.hi, e.lo, e.lat);
        end
      end
    end
    if (u_if.busy === 1'b1) bcnt++;
    else bcnt = 0;
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    u_if.start = 1'b1;
    u_if.op    = op;
    u_if.a     = a;
    u_if.b     = b;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    u_if.op    = 3'($urandom_range(0, 7));
    u_if.a     = $urandom;
    u_if.b     = $urandom;
  endtask

  task automatic wait_done(input string name, output int t);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (u_if.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    t = cyc;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done in 100 cycles expected a pulse", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                     input int lat);
    int t;
    exp_q.push_back('{hi: hi, lo: lo, lat: lat, name: name});
    issue(op, a, b);
    wait_done(name, t);
  endtask

  initial begin
    int t1;
    int t2;
    u_if.start = 1'b0;
    u_if.op    = 3'd0;
    u_if.a     = 32'd0;
    u_if.b     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_hi", u_if.hi_out, 32'd0);
    check("rst_lo", u_if.lo_out, 32'd0);
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_done", 32'(u_if.done), 32'd0);

    issue(3'b100, 32'h0000_1234, 32'd0);
    check("mthi_hi", u_if.hi_out, 32'h0000_1234);
    check("mthi_lo", u_if.lo_out, 32'd0);
    check("mthi_busy", 32'(u_if.busy), 32'd0);
    @(negedge clk);
    check("mthi_busy2", 32'(u_if.busy), 32'd0);

    issue(3'b110, 32'hAAAA_AAAA, 32'd1);
    check("nop_busy", 32'(u_if.busy), 32'd0);
    check("nop_hi", u_if.hi_out, 32'h0000_1234);

    run("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 4);
    run("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 4);
    run("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run("divu_by0", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
    run("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

    exp_q.push_back('{hi: 32'd2, lo: 32'd14, lat: 33, name: "b2b_first"});
    exp_q.push_back('{hi: 32'd2, lo: 32'd14, lat: 33, name: "b2b_second"});
    u_if.start = 1'b1;
    u_if.op    = 3'b011;
    u_if.a     = 32'd100;
    u_if.b     = 32'd7;
    @(posedge clk);
    wait_done("b2b_first", t1);
    u_if.start = 1'b0;
    wait_done("b2b_second", t2);
    check("b2b_gap", 32'(t2 - t1), 32'd34);

    exp_q.push_back('{hi: 32'd0, lo: 32'd15, lat: 4, name: "mult_under_mtlo"});
    issue(3'b000, 32'd3, 32'd5);
    issue(3'b101, 32'h0000_DEAD, 32'd0);
    check("mtlo_busy_ignored", u_if.lo_out, 32'd14);
    wait_done("mult_under_mtlo", t1);

    issue(3'b100, 32'h0000_0055, 32'd0);
    check("mthi_55", u_if.hi_out, 32'h0000_0055);
    issue(3'b011, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(u_if.busy), 32'd0);
    check("abort_hi", u_if.hi_out, 32'd0);
    check("abort_lo", u_if.lo_out, 32'd0);
    repeat (40) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle multiply/divide unit for the EX stage that owns the architectural HI and LO registers. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO requests from the ID/EX pipeline register. It produces registered `hi_out`/`lo_out` for the operand-2 handler, which reads them for MFHI/MFLO. It raises `busy` so the hazard/forwarding unit can stall IF/ID and ID/EX while an operation is in flight.

## Interface
- `MULT_LATENCY`, default 4: cycles from accept to HI/LO update for MULT/MULTU; legal range 1..8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request valid, taken from ID/EX (`ID_Enable_HI | ID_Enable_LO` qualified by the decoder).
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `a`  in  32  rs operand, already forwarded; dividend or multiplicand; MTHI/MTLO source.
- `b`  in  32  rt operand, already forwarded; divisor or multiplier.
- `busy`  out  1  high while a MULT/DIV operation is in progress; used as the stall request.
- `done`  out  1  one-cycle pulse on the cycle after HI/LO are written by a MULT/DIV.
- `hi_out`  out  32  architectural HI register.
- `lo_out`  out  32  architectural LO register.

## Operation
- States:
  - IDLE: the only state that accepts requests.
  - MUL: counts down `MULT_LATENCY`.
  - DIV: 32 restoring iterations.
  - FIX: sign correction and HI/LO write.
- Accept rule: `start=1` in IDLE is accepted at that edge. While not in IDLE, `start` is ignored; no queueing.
- MTHI/MTLO:
  - Completed at the accepting edge: `hi_out<=a` or `lo_out<=a`.
  - The other register is unchanged.
  - Never asserts `busy` or `done`. State stays IDLE.
- MULT/MULTU:
  - Operands are latched at accept; the signed or unsigned 64-bit product is formed.
  - `{hi_out,lo_out}<=product` after `MULT_LATENCY` cycles.
- DIV/DIVU, unsigned core:
  - Operands are latched at accept. Signed ops convert to magnitudes and record the quotient and remainder signs.
  - One quotient bit per cycle, MSB first, 64-bit remainder/quotient shift register.
- DIV/DIVU, FIX state:
  - Negates the quotient if the operand signs differ (signed op only).
  - Negates the remainder if the dividend was negative (signed op only).
  - Writes `LO=quotient`, `HI=remainder`.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero, both signed and unsigned: `HI=a` (original dividend), `LO=32'hFFFFFFFF`. Full DIV latency still applies.
- Overflow: `DIV 0x80000000 / 0xFFFFFFFF` gives `LO=0x80000000`, `HI=0`.
- Ops 110/111 with `start=1`: no state change, no `busy`.
- Source changes: `a`/`b`/`op` may change after the accepting edge without affecting the result.

## Timing
- Reset: on any edge with `reset=1`, `state<=IDLE`, `busy<=0`, `done<=0`, `hi_out<=0`, `lo_out<=0`, and the counter clears.
  - Reset has priority over `start`.
  - A reset mid-operation aborts it; no partial result is written.
- Accept at edge E:
  - `busy=1` from E until edge E+N, where it falls.
  - HI/LO are written at E+N.
  - `done=1` for exactly the cycle between E+N and E+N+1.
  - N=`MULT_LATENCY` for MULT/MULTU.
  - N=33 for DIV/DIVU: 32 iterations plus FIX.
- Back-to-back: in the `done=1` cycle the state is IDLE, so a new `start` is accepted at edge E+N+1 with no bubble.
- MTHI/MTLO at edge E: the new value is visible on `hi_out`/`lo_out` immediately after E. No forwarding inside the block.
- `hi_out`/`lo_out` hold their old values throughout `busy`. The hazard unit must stall MFHI/MFLO while `busy=1`.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset for 2 cycles, then `start=1`, `op=100`, `a=0x00001234` -> before start, all outputs 0. After one edge, `hi_out=0x00001234`, `lo_out=0`, `busy` never high.
- MULT and MULTU:
  - MULT `a=0xFFFFFFFD`, `b=7` -> `busy` high for exactly 4 cycles, then `hi_out=0xFFFFFFFF`, `lo_out=0xFFFFFFEB`, `done` pulses once.
  - MULTU `a=b=0xFFFFFFFF` -> `hi_out=0xFFFFFFFE`, `lo_out=0x00000001`.
- DIV and DIVU:
  - DIV `a=0xFFFFFFF9` (-7), `b=2` -> `busy` for 33 cycles, then `lo_out=0xFFFFFFFD`, `hi_out=0xFFFFFFFF`.
  - DIVU `a=100`, `b=7` -> `lo_out=14`, `hi_out=2`.
- Corner cases:
  - DIVU `a=5`, `b=0` -> `hi_out=5`, `lo_out=0xFFFFFFFF` after 33 cycles.
  - DIV `a=0x80000000`, `b=0xFFFFFFFF` -> `lo_out=0x80000000`, `hi_out=0`.
- Handshake:
  - Hold `start=1` with DIVU 100/7 continuously -> the second op is accepted only in the `done` cycle, and the second `done` arrives 34 cycles after the first.
  - MTLO issued while `busy` -> ignored, `lo_out` unchanged.
- Reset 10 cycles into DIV 100/7, after an earlier MTHI of `0x55` -> next edge: `busy=0`, `hi_out=0`, `lo_out=0`, and no `done` pulse afterward.
